// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_e    : controller state encoding (IDLE, CALC, FIX)
//   cnt_width  : iteration-counter width, clog2(w) with a floor of 1 bit
package seq_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Smallest r such that 2**r >= w, never less than one bit.
    function automatic int cnt_width(input int w);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < w) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mul_ctrl.sv
// Controller FSM for seq_mul_shift_add.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, honoured only in IDLE
//   zero_det   : remaining multiplier magnitude is zero (already gated by the
//                early-termination option in the datapath)
//   cnt_term   : iteration counter holds its last value (WIDTH-1)
//   load       : capture operands this edge
//   step       : perform one shift/add iteration this edge
//   fix        : write the signed-corrected product this edge
//   busy       : registered, high from capture edge until result edge
//   done       : registered single-cycle pulse after the result edge
module seq_mul_ctrl
    import seq_mul_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic zero_det,
    input  logic cnt_term,
    output logic load,
    output logic step,
    output logic fix,
    output logic busy,
    output logic done
);

    state_e state_r;
    state_e next_state_s;
    logic   busy_r;
    logic   done_r;

    // State register plus the registered busy/done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (state_r == ST_FIX);
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_CALC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                // The terminal count is the old counter value, so the final
                // iteration still runs on the edge that leaves CALC.
                if (zero_det || cnt_term) begin
                    next_state_s = ST_FIX;
                end else begin
                    next_state_s = ST_CALC;
                end
            end
            ST_FIX:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Datapath strobes decoded from the current state.
    always_comb begin
        load = 1'b0;
        step = 1'b0;
        fix  = 1'b0;
        case (state_r)
            ST_IDLE: load = start;
            ST_CALC: step = ~zero_det;
            ST_FIX:  fix  = 1'b1;
            default: begin
                load = 1'b0;
                step = 1'b0;
                fix  = 1'b0;
            end
        endcase
    end

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: rtl/seq_mul_shift_add.sv
// Sequential shift-add multiplier with signed/unsigned mode and optional
// early termination once the remaining multiplier bits are all zero.
//   WIDTH       : operand width (>= 2); product is 2*WIDTH bits
//   EARLY_TERM  : 1 = stop iterating when the remaining multiplier is zero
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, sampled only while idle
//   signed_mode : 1 = operands are two's complement
//   a, b        : multiplicand / multiplier, captured with start
//   busy        : operation in progress
//   done        : one-cycle pulse, product valid
//   product     : result register, held until the next result edge
module seq_mul_shift_add
    import seq_mul_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int EARLY_TERM = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = cnt_width(WIDTH);

    logic [PW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [PW-1:0]    acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sign_r;
    logic [PW-1:0]    product_r;

    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic             zero_det_s;
    logic             cnt_term_s;
    logic             load_s;
    logic             step_s;
    logic             fix_s;

    // Operand magnitudes; -2^(WIDTH-1) negates to itself, which is exactly
    // its unsigned magnitude.
    always_comb begin
        if (signed_mode && a[WIDTH-1]) begin
            mag_a_s = ~a + WIDTH'(1);
        end else begin
            mag_a_s = a;
        end
        if (signed_mode && b[WIDTH-1]) begin
            mag_b_s = ~b + WIDTH'(1);
        end else begin
            mag_b_s = b;
        end
    end

    // Status flags fed to the controller.
    always_comb begin
        if (EARLY_TERM != 0) begin
            zero_det_s = (mplier_r == '0);
        end else begin
            zero_det_s = 1'b0;
        end
        cnt_term_s = (cnt_r == CNT_W'(WIDTH - 1));
    end

    seq_mul_ctrl u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .zero_det (zero_det_s),
        .cnt_term (cnt_term_s),
        .load     (load_s),
        .step     (step_s),
        .fix      (fix_s),
        .busy     (busy),
        .done     (done)
    );

    // Iteration datapath: capture, shift/add, and final sign correction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r   <= '0;
            mplier_r  <= '0;
            acc_r     <= '0;
            cnt_r     <= '0;
            sign_r    <= 1'b0;
            product_r <= '0;
        end else begin
            if (load_s) begin
                mcand_r  <= {{WIDTH{1'b0}}, mag_a_s};
                mplier_r <= mag_b_s;
                acc_r    <= '0;
                cnt_r    <= '0;
                sign_r   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            end else if (step_s) begin
                if (mplier_r[0]) begin
                    acc_r <= acc_r + mcand_r;
                end else begin
                    acc_r <= acc_r;
                end
                mcand_r  <= {mcand_r[PW-2:0], 1'b0};
                mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                cnt_r    <= cnt_r + CNT_W'(1);
            end else begin
                mcand_r  <= mcand_r;
                mplier_r <= mplier_r;
                acc_r    <= acc_r;
                cnt_r    <= cnt_r;
            end
            if (fix_s) begin
                if (sign_r) begin
                    product_r <= ~acc_r + PW'(1);
                end else begin
                    product_r <= acc_r;
                end
            end else begin
                product_r <= product_r;
            end
        end
    end

    assign product = product_r;

endmodule

// File: doc/seq_mul_shift_add.md
# seq_mul_shift_add

Parametrised sequential shift-add multiplier. It generalises the repeated-addition multiplier to any operand width, adds a signed/unsigned mode, early termination on the remaining multiplier bits and a busy/done handshake. The block sits behind a bus or controller that issues one multiply at a time. It exposes a held product register so the result stays valid after `done` drops.

## Interface
- `WIDTH`, 16: operand width in bits. Must be at least 2. Product width is 2*WIDTH.
- `EARLY_TERM`, 1: when 1, iteration stops as soon as the remaining multiplier magnitude is zero. When 0, exactly WIDTH iterations always run.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only while idle.
- `signed_mode`  in  1  1 = a and b are two's complement; 0 = unsigned. Captured with start.
- `a`  in  WIDTH  multiplicand, captured with start.
- `b`  in  WIDTH  multiplier, captured with start.
- `busy`  out  1  high from the capture edge until the result edge.
- `done`  out  1  single-cycle pulse; `product` is valid in this cycle.
- `product`  out  2*WIDTH  result register, held until the next result edge.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE.** If `start` = 1 at an edge:
  - capture magnitudes |a| and |b|; in unsigned mode the magnitude is the raw value;
  - capture sign flag = sign(a) XOR sign(b) in signed mode, else 0;
  - clear accumulator and iteration counter; go to CALC; set `busy` = 1.
- **CALC**, per edge:
  - If EARLY_TERM = 1 and remaining multiplier magnitude = 0, go to FIX with no add.
  - Otherwise: add the shifted multiplicand into the accumulator if multiplier bit 0 = 1; shift the multiplicand left and the multiplier right; increment the counter.
  - If the counter reaches WIDTH-1 on this edge, go to FIX.
- **FIX**, one edge:
  - `product` <= accumulator, two's-complement negated over 2*WIDTH bits if the sign flag is set;
  - `done` <= 1 for one cycle, `busy` <= 0, go to IDLE.
- Arithmetic:
  - The accumulator and shifted multiplicand are 2*WIDTH bits wide.
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1); it fits the WIDTH-bit unsigned magnitude, so no overflow is possible.
  - The signed result always fits 2*WIDTH bits.
- `start` while `busy` = 1 is ignored. Operand changes during an operation have no effect.
- `start` in the `done` cycle is accepted, because the state is already IDLE. `product` keeps the finished result until the new operation's FIX edge.

## Timing
- Reset values:
  - state IDLE;
  - `busy` = 0, `done` = 0, `product` = 0;
  - accumulator, counter and sign flag = 0.
- Reset asserted mid-operation aborts immediately: `busy` and `done` go to 0 and `product` goes to 0. No result is produced.
- Let edge 0 be the start-capture edge. `done` is high during the cycle following edge L.
- Latency L:
  - EARLY_TERM = 0: L = WIDTH+1.
  - EARLY_TERM = 1, |b| = 0: L = 2.
  - EARLY_TERM = 1, otherwise: L = min(m+3, WIDTH+1), where m is the index of the MSB set in |b|.
- `busy` is high in the cycles after edges 0 through L-1 and low from edge L. `done` and `busy` are never high together.
- No combinational path exists from any input to any output.

## Structure
- Shared package `seq_mul_pkg` holds:
  - the state enum type (IDLE, CALC, FIX);
  - the counter-width function, clog2(WIDTH).
- Sub-module `seq_mul_ctrl` holds the FSM.
  - Inputs: `start`, zero-detect, counter terminal.
  - Outputs: load, shift/add enable, fix enable, `busy`, `done`.
- The top level holds the datapath: magnitude registers, accumulator, counter, sign flag and product register.

## Test plan
All cases use WIDTH = 16 unless stated.

- **Unsigned, early termination.** EARLY_TERM = 1, unsigned, a = 17, b = 5 -> `product` = 85. `done` after edge 5, `busy` for 5 cycles.
- **Signed small.** Signed, a = -3 (0xFFFD), b = 7 -> `product` = 0xFFFFFFEB, L = 5. Repeat with EARLY_TERM = 0 -> same product, L = 17.
- **Signed extreme.** Signed, a = b = 0x8000 -> `product` = 0x40000000, L = 17. Unsigned, a = b = 0xFFFF -> 0xFFFE0001.
- **Zero multiplier.** a = 1234, b = 0, EARLY_TERM = 1 -> `product` = 0 at L = 2. `done` pulses for exactly one cycle.
- **Handshake.**
  - Pulse `start` with 9×9 while busy running 17×5 -> the 9×9 request is ignored and `product` = 85.
  - Start 6×7 in the `done` cycle -> `product` stays 85 until it becomes 42.
- **Reset and width.**
  - Assert `rst_n` low mid-CALC -> `busy`, `done` and `product` read 0 immediately; the next operation runs normally.
  - WIDTH = 4, signed -8×-8 -> `product` = 0x40.
